// File: rtl/led_pattern_gen_if.sv
// LED pattern generator control/status bundle: mode, pause and brightness in,
// LED drive and step tick out.
interface led_pattern_gen_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PWM_BITS = 4
);
  logic [1:0]          mode;
  logic                pause;
  logic [PWM_BITS-1:0] brightness;
  logic [WIDTH-1:0]    leds;
  logic                tick;

  modport master (
    output mode,
    output pause,
    output brightness,
    input  leds,
    input  tick
  );

  modport slave (
    input  mode,
    input  pause,
    input  brightness,
    output leds,
    output tick
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Four-animation LED pattern generator (gray count, rule-30, bouncing dot,
// binary count) stepped by a prescaler tick, with PWM brightness gating and
// a pause control. All generators advance together; mode only picks the view.
module led_pattern_gen #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LOG2DELAY = 22,
  parameter int unsigned PWM_BITS  = 4
) (
  input logic              clk,
  input logic              rst,
  led_pattern_gen_if.slave bus
);

  localparam int unsigned PosW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [31:0] CaSeed = 32'h0001_0000;

  typedef enum logic {StUp, StDown} dir_e;

  logic [LOG2DELAY-1:0] presc_q;
  logic [PWM_BITS-1:0]  pwm_cnt_q;
  logic [WIDTH-1:0]     step_q;
  logic [31:0]          ca_q;
  logic [31:0]          ca_d;
  logic [PosW-1:0]      pos_q;
  dir_e                 dir_q;
  logic [WIDTH-1:0]     pattern;
  logic [WIDTH-1:0]     leds_q;
  logic                 tick;
  logic                 gate;

  // A paused prescaler sitting at all-ones holds the step until resume.
  assign tick     = (presc_q == '1) & ~bus.pause;
  assign gate     = (bus.brightness == '1) | (pwm_cnt_q < bus.brightness);
  assign bus.tick = tick;
  assign bus.leds = leds_q;

  // Step prescaler (freezes on pause) and PWM counter (always runs).
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      if (!bus.pause) begin
        presc_q <= presc_q + LOG2DELAY'(1);
      end
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  // Rule 30 on a 32-cell ring: left neighbour is i+1, right neighbour is i-1.
  always_comb begin
    ca_d = '0;
    for (int i = 0; i < 32; i++) begin
      ca_d[i] = ca_q[(i + 1) % 32] ^ (ca_q[i] | ca_q[(i + 31) % 32]);
    end
  end

  // Pattern state: counter, automaton and bounce FSM all advance on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
      ca_q   <= CaSeed;
      pos_q  <= '0;
      dir_q  <= StUp;
    end else if (tick) begin
      step_q <= step_q + WIDTH'(1);
      ca_q   <= ca_d;
      // A single LED has nowhere to bounce, so pos stays 0.
      if (WIDTH > 1) begin
        unique case (dir_q)
          StUp: begin
            if (pos_q == PosW'(WIDTH - 1)) begin
              pos_q <= PosW'(WIDTH - 2);
              dir_q <= StDown;
            end else begin
              pos_q <= pos_q + PosW'(1);
            end
          end
          StDown: begin
            if (pos_q == '0) begin
              pos_q <= PosW'(1);
              dir_q <= StUp;
            end else begin
              pos_q <= pos_q - PosW'(1);
            end
          end
        endcase
      end
    end
  end

  // Select the displayed animation.
  always_comb begin
    pattern = '0;
    case (bus.mode)
      2'd0:    pattern = step_q ^ (step_q >> 1);
      2'd1:    pattern = ca_q[7 +: WIDTH];
      2'd2:    pattern = WIDTH'(1) << pos_q;
      default: pattern = step_q;
    endcase
  end

  // Registered, PWM-gated LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q <= '0;
    end else begin
      leds_q <= pattern & {WIDTH{gate}};
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (WIDTH=8, LOG2DELAY=2, PWM_BITS=4).
// The reference model counts unpaused cycles, ticks and PWM cycles as plain
// integers and derives each pattern directly from the tick count.
module tb_led_pattern_gen;

  localparam int unsigned W   = 8;
  localparam int unsigned LD  = 2;
  localparam int unsigned PB  = 4;
  localparam int          PER = 1 << LD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_pattern_gen_if #(.WIDTH(W), .PWM_BITS(PB)) bus ();

  led_pattern_gen #(
    .WIDTH    (W),
    .LOG2DELAY(LD),
    .PWM_BITS (PB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int           m_unp;    // unpaused cycles since reset
  int           m_ticks;  // pattern steps since reset
  int           m_pwm;    // cycles since reset
  logic [31:0]  m_ca;
  logic [W-1:0] m_leds;

  function automatic logic [31:0] rule30(input logic [31:0] c);
    logic [31:0] left;
    logic [31:0] right;
    left  = {c[0], c[31:1]};
    right = {c[30:0], c[31]};
    return left ^ (c | right);
  endfunction

  function automatic logic [W-1:0] model_pattern(input int n, input logic [1:0] md,
                                                 input logic [31:0] ca);
    int s;
    int p;
    int pos;
    s   = n % 256;
    p   = n % (2 * (W - 1));
    pos = (p <= W - 1) ? p : 2 * (W - 1) - p;
    case (md)
      2'd0:    return W'(s ^ (s >> 1));
      2'd1:    return ca[14:7];
      2'd2:    return W'(1 << pos);
      default: return W'(s);
    endcase
  endfunction

  function automatic logic exp_tick();
    return ((m_unp % PER) == PER - 1) && !bus.pause;
  endfunction

  // Advance one clock edge and update the model with the inputs seen there.
  task automatic cycle();
    logic g;
    @(posedge clk);
    if (rst) begin
      m_unp   = 0;
      m_ticks = 0;
      m_pwm   = 0;
      m_ca    = 32'h0001_0000;
      m_leds  = '0;
    end else begin
      g = (bus.brightness == 4'hF) || ((m_pwm % 16) < int'(bus.brightness));
      m_leds = g ? model_pattern(m_ticks, bus.mode, m_ca) : '0;
      if (((m_unp % PER) == PER - 1) && !bus.pause) begin
        m_ticks++;
        m_ca = rule30(m_ca);
      end
      if (!bus.pause) m_unp++;
      m_pwm++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Run until n more ticks have been taken, then one edge so leds shows them.
  task automatic run_ticks(input int n);
    int target;
    target = m_ticks + n;
    for (int i = 0; i < 4096 && m_ticks < target; i++) cycle();
    cycle();
  endtask

  task automatic test_reset();
    bus.mode = 2'd2; bus.pause = 1'b0; bus.brightness = 4'hF;
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (bus.leds !== 8'h00) begin
      errors++; $display("FAIL reset_leds: got %h expected 00", bus.leds);
    end
    checks++;
    if (bus.tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick: got %b expected 0", bus.tick);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (bus.leds !== 8'h01) begin
      errors++; $display("FAIL reset_mode2_leds: got %h expected 01", bus.leds);
    end
  endtask

  task automatic test_gray();
    bus.mode = 2'd0; bus.pause = 1'b0; bus.brightness = 4'hF;
    do_reset();
    run_ticks(3);
    checks++;
    if (bus.leds !== 8'h02) begin
      errors++; $display("FAIL gray_3: got %h expected 02", bus.leds);
    end
    run_ticks(253);
    checks++;
    if (bus.leds !== 8'h00) begin
      errors++; $display("FAIL gray_wrap: got %h expected 00", bus.leds);
    end
  endtask

  task automatic test_rule30();
    bus.mode = 2'd1; bus.pause = 1'b0; bus.brightness = 4'hF;
    do_reset();
    run_ticks(1);
    checks++;
    if (bus.leds !== 8'h00) begin
      errors++; $display("FAIL rule30_1: got %h expected 00", bus.leds);
    end
    run_ticks(1);
    checks++;
    if (bus.leds !== 8'h80) begin
      errors++; $display("FAIL rule30_2: got %h expected 80", bus.leds);
    end
    run_ticks(5);
    checks++;
    if (bus.leds !== m_leds) begin
      errors++; $display("FAIL rule30_7: got %h expected %h", bus.leds, m_leds);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_tbl [15];
    exp_tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    bus.mode = 2'd2; bus.pause = 1'b0; bus.brightness = 4'hF;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      run_ticks(1);
      checks++;
      if (bus.leds !== exp_tbl[k]) begin
        errors++;
        $display("FAIL bounce_tick%0d: got %h expected %h", k + 1, bus.leds, exp_tbl[k]);
      end
    end
  endtask

  task automatic test_pause_spacing();
    int last;
    int found;
    logic [W-1:0] held;
    bus.mode = 2'd3; bus.pause = 1'b0; bus.brightness = 4'hF;
    do_reset();
    last  = -1;
    for (int c = 0; c < 24; c++) begin
      if (bus.tick === 1'b1) begin
        checks++;
        if ((last < 0 && c != PER - 1) || (last >= 0 && c - last != PER)) begin
          errors++; $display("FAIL tick_spacing: tick at cycle %0d, previous %0d", c, last);
        end
        last = c;
      end
      cycle();
    end
    // Stop on a cycle where a tick is pending, then hold pause.
    found = 0;
    for (int c = 0; c < 16 && found == 0; c++) begin
      if (bus.tick === 1'b1) found = 1;
      else cycle();
    end
    checks++;
    if (found == 0) begin
      errors++; $display("FAIL tick_timeout: got no tick expected one within 16 cycles");
    end
    bus.pause = 1'b1;
    #1;
    held = bus.leds;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.tick !== 1'b0 || bus.leds !== held) begin
        errors++;
        $display("FAIL pause_hold%0d: tick %b leds %h expected tick 0 leds %h",
                 c, bus.tick, bus.leds, held);
      end
      cycle();
    end
    bus.pause = 1'b0;
    #1;
    checks++;
    if (bus.tick !== 1'b1) begin
      errors++; $display("FAIL pause_resume_tick: got %b expected 1", bus.tick);
    end
    cycle();
    for (int c = 1; c < PER; c++) begin
      checks++;
      if (bus.tick !== 1'b0) begin
        errors++; $display("FAIL resume_gap%0d: got %b expected 0", c, bus.tick);
      end
      cycle();
    end
    checks++;
    if (bus.tick !== 1'b1) begin
      errors++; $display("FAIL resume_next_tick: got %b expected 1", bus.tick);
    end
  endtask

  task automatic test_brightness();
    int on_cnt;
    int bad_cnt;
    logic [3:0] lvl [3];
    int exp_on [3];
    lvl    = '{4'd4, 4'd0, 4'hF};
    exp_on = '{4, 0, 16};
    bus.mode = 2'd3; bus.pause = 1'b0; bus.brightness = 4'hF;
    do_reset();
    run_ticks(5);
    bus.pause = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.brightness = lvl[j];
      cycle();
      on_cnt  = 0;
      bad_cnt = 0;
      for (int c = 0; c < 16; c++) begin
        if (bus.leds === 8'h05) on_cnt++;
        else if (bus.leds !== 8'h00) bad_cnt++;
        cycle();
      end
      checks++;
      if (on_cnt != exp_on[j] || bad_cnt != 0) begin
        errors++;
        $display("FAIL brightness_%h: on %0d other %0d expected on %0d other 0",
                 lvl[j], on_cnt, bad_cnt, exp_on[j]);
      end
    end
    bus.pause = 1'b0;
    bus.brightness = 4'hF;
  endtask

  task automatic test_reset_mid();
    bus.mode = 2'd2; bus.pause = 1'b0; bus.brightness = 4'hF;
    do_reset();
    run_ticks(9);
    checks++;
    if (bus.leds !== 8'h20) begin
      errors++; $display("FAIL mid_pre: got %h expected 20", bus.leds);
    end
    rst = 1'b1;
    cycle();
    checks++;
    if (bus.leds !== 8'h00) begin
      errors++; $display("FAIL mid_reset_leds: got %h expected 00", bus.leds);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (bus.leds !== 8'h01 || bus.tick !== 1'b0) begin
      errors++; $display("FAIL mid_release: leds %h tick %b expected 01 0", bus.leds, bus.tick);
    end
    cycle();
    checks++;
    if (bus.tick !== 1'b0) begin
      errors++; $display("FAIL mid_no_early_tick: got %b expected 0", bus.tick);
    end
    cycle();
    checks++;
    if (bus.tick !== 1'b1) begin
      errors++; $display("FAIL mid_first_tick: got %b expected 1", bus.tick);
    end
    cycle();
    cycle();
    checks++;
    if (bus.leds !== 8'h02) begin
      errors++; $display("FAIL mid_pos1: got %h expected 02", bus.leds);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bus.mode       = 2'($urandom_range(0, 3));
      bus.pause      = ($urandom_range(0, 4) == 0);
      bus.brightness = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      rst            = ($urandom_range(0, 99) == 0);
      #1;
      checks++;
      if (bus.tick !== (rst ? bus.tick : exp_tick())) begin
        errors++; $display("FAIL rand_tick%0d: got %b expected %b", c, bus.tick, exp_tick());
      end
      cycle();
      checks++;
      if (bus.leds !== m_leds) begin
        errors++; $display("FAIL rand_leds%0d: got %h expected %h", c, bus.leds, m_leds);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.mode       = 2'd0;
    bus.pause      = 1'b0;
    bus.brightness = 4'hF;
    m_unp   = 0;
    m_ticks = 0;
    m_pwm   = 0;
    m_ca    = 32'h0001_0000;
    m_leds  = '0;
    test_reset();
    test_gray();
    test_rule30();
    test_bounce();
    test_pause_spacing();
    test_brightness();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
